// File: rtl/wired0_defines.sv
// Shared I-cache definitions: line geometry, tag layout and refill FSM encoding.
package wired0_defines;

  localparam int unsigned ICACHE_LINE_WORDS = 4;
  localparam int unsigned ICACHE_WAYS       = 4;

  typedef struct packed {
    logic        valid;
    logic [19:0] ppn;
  } cache_tag_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRecv,
    StResp,
    StDrain
  } irefill_fsm_t;

endpackage

// File: rtl/wired_icache_refill_if.sv
// Signal bundle between the refill controller and F2, the read bus and the I-cache SRAMs.
interface wired_icache_refill_if
  import wired0_defines::*;
#(
  parameter int unsigned WAYS = ICACHE_WAYS
) ();

  logic              m_valid_i;
  logic              m_ready_o;
  logic [31:0]       m_paddr_i;
  logic              m_uncache_i;
  logic              r_valid_o;
  logic              r_ready_i;
  logic [1:0][31:0]  r_inst_o;
  logic              r_berr_o;
  logic              br_valid_o;
  logic              br_ready_i;
  logic [31:0]       br_addr_o;
  logic [1:0]        br_len_o;
  logic              bd_valid_i;
  logic [31:0]       bd_data_i;
  logic              bd_last_i;
  logic              bd_err_i;
  logic [WAYS-1:0]   d_we_o;
  logic [8:0]        d_addr_o;
  logic [63:0]       d_wdata_o;
  logic [WAYS-1:0]   t_we_o;
  logic [7:0]        t_addr_o;
  cache_tag_t        t_wdata_o;
  logic              flush_i;

  // Refill controller side.
  modport master (
    input  m_valid_i, m_paddr_i, m_uncache_i, r_ready_i, br_ready_i,
    input  bd_valid_i, bd_data_i, bd_last_i, bd_err_i, flush_i,
    output m_ready_o, r_valid_o, r_inst_o, r_berr_o, br_valid_o, br_addr_o, br_len_o,
    output d_we_o, d_addr_o, d_wdata_o, t_we_o, t_addr_o, t_wdata_o
  );

  // Pipeline / bus / SRAM side.
  modport slave (
    output m_valid_i, m_paddr_i, m_uncache_i, r_ready_i, br_ready_i,
    output bd_valid_i, bd_data_i, bd_last_i, bd_err_i, flush_i,
    input  m_ready_o, r_valid_o, r_inst_o, r_berr_o, br_valid_o, br_addr_o, br_len_o,
    input  d_we_o, d_addr_o, d_wdata_o, t_we_o, t_addr_o, t_wdata_o
  );

endinterface

// File: rtl/wired_icache_victim.sv
// Round-robin victim way selector; advances once per validated line fill.
module wired_icache_victim #(
  parameter int unsigned WAYS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance_i,
  output logic [WAYS-1:0] way_oh_o
);

  localparam int unsigned CntW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      cnt_d = (cnt_q == CntW'(WAYS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign way_oh_o = WAYS'(1) << cnt_q;

endmodule

// File: rtl/wired_icache_refill.sv
// I-cache miss/refill controller: one burst per miss, line fill into a round-robin victim way,
// fetch-pair return to F2. Flushed bursts are always drained and still fill the line.
module wired_icache_refill
  import wired0_defines::*;
#(
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned WAYS       = ICACHE_WAYS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wired_icache_refill_if.master bus
);

  localparam int unsigned BeatW = $clog2(LINE_WORDS);

  irefill_fsm_t                    state_q, state_d;
  logic [31:3]                     paddr_q, paddr_d;
  logic                            uncache_q, uncache_d;
  logic                            err_q, err_d;
  logic [BeatW-1:0]                beat_q, beat_d;
  logic [LINE_WORDS-1:0][31:0]     line_q;

  logic                            beat_fire;
  logic                            wr_ok;
  logic                            victim_adv;
  logic [WAYS-1:0]                 victim_oh;
  logic [BeatW-1:0]                pair_lo;

  wired_icache_victim #(
    .WAYS(WAYS)
  ) u_victim (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (victim_adv),
    .way_oh_o  (victim_oh)
  );

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    uncache_d = uncache_q;
    err_d     = err_q;
    beat_d    = beat_q;

    bus.m_ready_o  = 1'b0;
    bus.r_valid_o  = 1'b0;
    bus.r_berr_o   = 1'b0;
    bus.br_valid_o = 1'b0;

    beat_fire = (state_q == StRecv || state_q == StDrain) && bus.bd_valid_i;
    // Any error in the burst, including on the current beat, blocks further fills.
    wr_ok      = beat_fire && !uncache_q && !err_q && !bus.bd_err_i;
    victim_adv = wr_ok && bus.bd_last_i;

    if (beat_fire) begin
      beat_d = bus.bd_last_i ? '0 : beat_q + 1'b1;
      if (bus.bd_err_i) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        bus.m_ready_o = 1'b1;
        if (bus.m_valid_i && !bus.flush_i) begin
          paddr_d   = bus.m_paddr_i[31:3];
          uncache_d = bus.m_uncache_i;
          err_d     = 1'b0;
          beat_d    = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        bus.br_valid_o = 1'b1;
        if (bus.flush_i) begin
          state_d = bus.br_ready_i ? StDrain : StIdle;
        end else if (bus.br_ready_i) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (beat_fire && bus.bd_last_i) begin
          state_d = bus.flush_i ? StIdle : StResp;
        end else if (bus.flush_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (beat_fire && bus.bd_last_i) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        bus.r_valid_o = 1'b1;
        bus.r_berr_o  = err_q;
        if (bus.r_ready_i || bus.flush_i) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.br_addr_o = uncache_q ? {paddr_q[31:3], 3'b000} : {paddr_q[31:4], 4'b0000};
    bus.br_len_o  = uncache_q ? 2'd1 : 2'(LINE_WORDS - 1);

    // Odd beats complete a 64-bit pair: write it with the buffered even beat.
    bus.d_we_o    = (wr_ok && beat_q[0]) ? victim_oh : '0;
    bus.d_addr_o  = {paddr_q[11:4], beat_q[BeatW-1]};
    bus.d_wdata_o = {bus.bd_data_i, line_q[beat_q & ~BeatW'(1)]};

    bus.t_we_o          = victim_adv ? victim_oh : '0;
    bus.t_addr_o        = paddr_q[11:4];
    bus.t_wdata_o.valid = 1'b1;
    bus.t_wdata_o.ppn   = paddr_q[31:12];

    pair_lo         = uncache_q ? '0 : {paddr_q[BeatW+1:3], 1'b0};
    bus.r_inst_o[0] = line_q[pair_lo];
    bus.r_inst_o[1] = line_q[pair_lo | BeatW'(1)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      uncache_q <= 1'b0;
      err_q     <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      uncache_q <= uncache_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
    end
  end

  // Line buffer is data-only; stale contents are never presented without a refill.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      line_q[beat_q] <= bus.bd_data_i;
    end
  end

endmodule

// File: doc/wired_icache_refill.md
Name: wired_icache_refill

Overview:
Miss/refill controller for the instruction cache. It accepts one miss or uncached request at a time from the I-cache F2 stage and issues a single burst read on a 32-bit bus. For cached requests it writes the returned 16-byte line into the data and tag SRAMs of a round-robin victim way. It then returns the 8-byte fetch pair (two instructions) to F2. Flush aborts delivery but always drains the outstanding burst.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line (line = 16 B, index = paddr[11:4]).
WAYS, 4, number of ways; victim counter width is log2(WAYS).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m_valid_i  in  1  miss request valid
m_ready_o  out  1  controller can accept a request
m_paddr_i  in  32  physical fetch address (8-byte aligned; paddr[1:0] ignored)
m_uncache_i  in  1  1 = uncached fetch, no SRAM write
r_valid_o  out  1  fetch pair result valid
r_ready_i  in  1  F2 accepts result
r_inst_o  out  2x32  words at {paddr[31:3],3'b000} and +4
r_berr_o  out  1  bus error during the fetch
br_valid_o  out  1  bus read request valid
br_ready_i  in  1  bus accepts request
br_addr_o  out  32  burst start address
br_len_o  out  2  beats minus 1 (3 = cached, 1 = uncached)
bd_valid_i  in  1  read beat valid (no back-pressure)
bd_data_i  in  32  beat data
bd_last_i  in  1  final beat
bd_err_i  in  1  beat error
d_we_o  out  WAYS  data SRAM way write mask (one-hot)
d_addr_o  out  9  data SRAM address = paddr[11:3]
d_wdata_o  out  64  data write, {word1,word0}
t_we_o  out  WAYS  tag SRAM way write mask (one-hot)
t_addr_o  out  8  tag SRAM index = paddr[11:4]
t_wdata_o  out  cache_tag_t  {valid=1, ppn=paddr[31:12]}
flush_i  in  1  pipeline flush

Behaviour:
- Reset: state IDLE; m_ready_o=1; r_valid_o, br_valid_o, d_we_o, t_we_o, r_berr_o = 0; victim counter = 0; beat counter = 0.
- States: IDLE, REQ, RECV, RESP, DRAIN.
- IDLE: m_ready_o=1. On m_valid_i, latch paddr/uncache and go to REQ. m_ready_o is 0 in every other state.
- REQ: br_valid_o=1. br_addr_o = {paddr[31:4],4'b0} for cached, {paddr[31:3],3'b0} for uncached. Hold stable until br_ready_i, then go to RECV.
- RECV: each bd_valid_i stores bd_data_i at beat index and increments the beat counter (wraps mod LINE_WORDS).
  - Cached: on each odd beat k with no error since the burst started, pulse d_we_o = onehot(victim) for one cycle, with d_addr_o = {paddr[11:4],k[1]} and d_wdata_o = {beat k, beat k-1}.
  - On bd_last_i: if no error has occurred and the request is cached, pulse t_we_o = onehot(victim) in the same cycle and increment victim (mod WAYS). Then go to RESP.
- Errors: bd_err_i on any beat sets a sticky error flag. Later d_we_o pulses and the tag write are suppressed, so the line is never validated. Data already written without a tag is harmless.
- RESP: r_valid_o=1. r_inst_o is the latched pair selected by paddr[3] (cached) or beats 0/1 (uncached). r_berr_o = error flag. On r_ready_i go to IDLE and clear the flag. Latency from request accept to r_valid_o is 2 + burst cycles, minimum 6 cycles cached with back-to-back beats.
- Flush:
  - In REQ before acceptance: drop the request, go to IDLE.
  - In REQ on the same cycle as br_ready_i, or in RECV: go to DRAIN.
  - In RESP: drop r_valid_o next cycle, go to IDLE.
  - In IDLE: a coincident m_valid_i is ignored.
- DRAIN: keeps consuming beats and performs SRAM writes exactly as RECV (the line stays coherent and useful). On bd_last_i, go to IDLE without asserting r_valid_o.
- Simultaneous events: flush_i with bd_last_i in RECV still performs the tag write, then goes to IDLE. A snoop hazard is not handled here; the F1 snoop path covers it.
- Reset mid-burst: all state cleared. The bus interconnect is reset in the same domain, so no orphan beats arrive.

Decomposition:
- Shared package (wired0_defines): cache_tag_t (existing), ICACHE_LINE_WORDS, ICACHE_WAYS, and an enum typedef irefill_fsm_t.
- The victim selector (round-robin counter, later replaceable by PLRU) is a natural sub-module: wired_icache_victim (inputs: advance; output: one-hot way).
- Everything else stays flat.

Test Plan:
- Cached miss, paddr=0x1C00_0148, beats 0xA0..0xA3 back-to-back, victim=0.
  - Expect br_addr_o=0x1C00_0140, br_len_o=3.
  - Expect d_we_o=4'b0001 at addr 0x28 then 0x29, data {A1,A0}, {A3,A2}.
  - Expect t_we_o=0001, t_addr_o=0x14, ppn=0x1C000.
  - Expect r_inst_o={A3,A2} (pair at paddr[3]=1), r_berr_o=0; victim becomes 1.
- Four consecutive cached misses: t_we_o masks 0001, 0010, 0100, 1000, then 0001 on the fifth.
- Uncached, paddr=0x1FE0_0004: br_addr_o=0x1FE0_0000, br_len_o=1, no d_we_o/t_we_o pulses, r_inst_o = beats 0/1.
- bd_err_i on beat 2 of a cached burst: first d_we_o pulse only, no t_we_o, r_berr_o=1, victim unchanged.
- flush_i during RECV after beat 1: remaining beats drained, both data writes and the tag write occur, r_valid_o never asserts, m_ready_o returns to 1 the cycle after bd_last_i.
- br_ready_i held low for 5 cycles: br_valid_o and br_addr_o stay stable. flush_i on cycle 3 leads to IDLE with no bus transfer.
